// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : One-entry registered branch resolve stage with saturating
//            mispredict counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_0,
    input  logic [XLEN-1:0]   in_1,
    input  logic [2:0]        mode,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              pred_taken,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic              out_mispredict,
    output logic              out_illegal,
    output logic [XLEN-1:0]   out_target,
    output logic [CNT_W-1:0]  mispredict_count
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [XLEN-1:0]  c_four    = XLEN'(4);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_eq;
    logic              w_lt;
    logic              w_ltu;
    logic              w_taken;
    logic              w_illegal;
    logic [XLEN-1:0]   w_target;
    logic              w_cnt_inc;

    assign out_valid = (r_state == S_FULL);
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        in_ready    = (!out_valid || out_ready) && !flush;
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else if (w_accept) begin
            w_state_nxt = S_FULL;
        end else if (out_ready) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_eq  = (in_0 == in_1);
    assign w_lt  = ($signed(in_0) < $signed(in_1));
    assign w_ltu = (in_0 < in_1);

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (mode)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = !w_eq;
            3'b100:  w_taken = w_lt;
            3'b101:  w_taken = !w_lt;
            3'b110:  w_taken = w_ltu;
            3'b111:  w_taken = !w_ltu;
            default: w_illegal = 1'b1;
        endcase
    end

    // Sum wraps naturally at XLEN bits.
    assign w_target = w_taken ? (pc + imm) : (pc + c_four);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
            out_target     <= '0;
        end else if (w_accept) begin
            out_taken      <= w_taken;
            out_mispredict <= !w_illegal && (w_taken ^ pred_taken);
            out_illegal    <= w_illegal;
            out_target     <= w_target;
        end
    end

    assign w_cnt_inc = out_valid && out_ready && out_mispredict && !flush;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_count <= '0;
        end else if (cnt_clr) begin
            mispredict_count <= '0;
        end else if (w_cnt_inc && (mispredict_count != c_cnt_max)) begin
            mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module   : tb_branch_resolve_unit
// Brief    : Directed vector bench for branch_resolve_unit (XLEN=32, CNT_W=16/2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, flush, cnt_clr, pred_taken;
    logic [31:0] in_0, in_1, pc, imm;
    logic [2:0]  mode;

    logic        a_in_ready, a_valid, a_taken, a_mis, a_ill;
    logic [31:0] a_target;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_valid, b_taken, b_mis, b_ill;
    logic [31:0] b_target;
    logic [1:0]  b_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_0(in_0), .in_1(in_1), .mode(mode), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(a_valid), .out_ready(out_ready), .out_taken(a_taken),
        .out_mispredict(a_mis), .out_illegal(a_ill), .out_target(a_target),
        .mispredict_count(a_cnt)
    );

    branch_resolve_unit #(.XLEN(32), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_0(in_0), .in_1(in_1), .mode(mode), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(b_valid), .out_ready(out_ready), .out_taken(b_taken),
        .out_mispredict(b_mis), .out_illegal(b_ill), .out_target(b_target),
        .mispredict_count(b_cnt)
    );

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic        taken;
        logic        mis;
        logic        ill;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] p, input logic [31:0] i, input logic pr,
                                input logic t, input logic ms, input logic il, input logic [31:0] tg);
        vec_t v;
        v.mode = m; v.a = a; v.b = b; v.pc = p; v.imm = i; v.pred = pr;
        v.taken = t; v.mis = ms; v.ill = il; v.tgt = tg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        mode = v.mode; in_0 = v.a; in_1 = v.b; pc = v.pc; imm = v.imm; pred_taken = v.pred;
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, ".valid"},  32'(a_valid),  32'd1);
        chk({tag, ".taken"},  32'(a_taken),  32'(v.taken));
        chk({tag, ".mis"},    32'(a_mis),    32'(v.mis));
        chk({tag, ".ill"},    32'(a_ill),    32'(v.ill));
        chk({tag, ".target"}, a_target,      v.tgt);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".cnt_a"}, 32'(a_cnt), 32'(exp_cnt));
        chk({tag, ".cnt_b"}, 32'(b_cnt), 32'((exp_cnt > 3) ? 3 : exp_cnt));
    endtask

    initial begin
        vecs[0]  = mk(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h0000_0100, 32'h0000_0020, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0120);
        vecs[1]  = mk(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h0000_0100, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0104);
        vecs[2]  = mk(3'b000, 32'd5,         32'd5, 32'h0000_1000, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0FF0);
        vecs[3]  = mk(3'b001, 32'd5,         32'd5, 32'h0000_2000, 32'h0000_0008, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2004);
        vecs[4]  = mk(3'b101, 32'h8000_0000, 32'd0, 32'h0000_0300, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0304);
        vecs[5]  = mk(3'b111, 32'h8000_0000, 32'd0, 32'h0000_0300, 32'h0000_0040, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0340);
        vecs[6]  = mk(3'b000, 32'd1,         32'd2, 32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        vecs[7]  = mk(3'b010, 32'd3,         32'd3, 32'h0000_0400, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0404);
        vecs[8]  = mk(3'b011, 32'd1,         32'd9, 32'h0000_0500, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0504);
        vecs[9]  = mk(3'b100, 32'd7,         32'd7, 32'h0000_0600, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0604);
        vecs[10] = mk(3'b101, 32'd7,         32'd7, 32'h0000_0700, 32'h0000_0010, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0710);
        vecs[11] = mk(3'b001, 32'd1,         32'd2, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        apply(vecs[0]);
        repeat (2) tick();
        chk("rst.valid",  32'(a_valid), 32'd0);
        chk("rst.target", a_target,     32'd0);
        chk_cnt("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 32'(a_in_ready), 32'd1);

        // Table: full-throughput stream, one result per cycle.
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            chk_result($sformatf("vec%0d", i), vecs[i]);
            chk_cnt($sformatf("vec%0d", i));
            exp_cnt += int'(vecs[i].mis);
        end
        in_valid = 1'b0;
        tick();
        chk("drain.valid", 32'(a_valid), 32'd0);
        chk_cnt("drain");

        // Stall with out_ready low, then release into back-to-back results.
        apply(vecs[0]); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        apply(vecs[1]); out_ready = 1'b0;
        #1;
        chk("stall.in_ready", 32'(a_in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_result($sformatf("stall%0d", k), vecs[0]);
            chk($sformatf("stall%0d.in_ready", k), 32'(a_in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", 32'(a_in_ready), 32'd1);
        tick();
        exp_cnt += 1;
        chk_result("b2b0", vecs[1]);
        chk_cnt("b2b0");
        apply(vecs[2]);
        tick();
        chk_result("b2b1", vecs[2]);
        chk_cnt("b2b1");

        // Clear coincident with an increment.
        apply(vecs[0]);
        tick();
        chk_result("preclr", vecs[0]);
        in_valid = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        exp_cnt = 0;
        chk_cnt("clr");

        // Flush while FULL with a mispredicting result ready to hand off.
        apply(vecs[0]); in_valid = 1'b1;
        tick();
        chk_result("preflush", vecs[0]);
        flush = 1'b1;
        #1;
        chk("flush.in_ready", 32'(a_in_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush.valid", 32'(a_valid), 32'd0);
        chk_cnt("flush");

        // Asynchronous reset mid-cycle discards the held result.
        tick();
        tick();
        exp_cnt = 1;
        chk_result("prerst", vecs[0]);
        chk_cnt("prerst");
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("arst.valid",  32'(a_valid), 32'd0);
        chk("arst.taken",  32'(a_taken), 32'd0);
        chk("arst.mis",    32'(a_mis),   32'd0);
        chk("arst.ill",    32'(a_ill),   32'd0);
        chk("arst.target", a_target,     32'd0);
        chk_cnt("arst");
        apply(vecs[1]); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        chk_result("postrst", vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32: operand, PC and immediate width in bits.
REQ-002 Parameter CNT_W, default 16: width of the mispredict counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  reset, asynchronous assert, active low.
REQ-006 in_valid  in  1  request valid.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 in_0, in_1  in  XLEN each  rs1 and rs2 operands.
REQ-009 mode  in  3  comparison code: EQ=000, NE=001, LT=100, GE=101, LTU=110, GEU=111.
REQ-010 pc, imm  in  XLEN each  branch PC and sign-extended offset.
REQ-011 pred_taken  in  1  front-end prediction.
REQ-012 flush  in  1  pipeline kill.
REQ-013 cnt_clr  in  1  synchronous clear of the mispredict counter.
REQ-014 out_valid  out  1  result valid.
REQ-015 out_ready  in  1  consumer accepts the result.
REQ-016 out_taken, out_mispredict, out_illegal  out  1 each  registered results.
REQ-017 out_target  out  XLEN  resolved next PC.
REQ-018 mispredict_count  out  CNT_W  saturating mispredict count.

Function
REQ-019 The block SHALL be a one-entry registered stage with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-021 An accept occurs when in_valid && in_ready; results are registered at that edge, giving a latency of exactly 1 cycle.
REQ-022 EQ/NE: taken on equality / inequality of in_0 and in_1.
REQ-023 LT/GE: taken on signed comparison; LTU/GEU: taken on unsigned comparison.
REQ-024 Codes 010 and 011: out_taken=0, out_illegal=1, out_mispredict=0.
REQ-025 out_target SHALL be pc+imm if taken, else pc+4, truncated modulo 2^XLEN (wrap-around, no overflow flag).
REQ-026 For legal modes, out_mispredict SHALL be out_taken XOR pred_taken.
REQ-027 Transitions: EMPTY->FULL on accept; FULL->FULL on accept with out_ready (back-to-back, full throughput); FULL->EMPTY on out_ready without accept; FULL holds all outputs stable while out_ready=0.
REQ-028 flush SHALL force the next state to EMPTY regardless of in_valid or out_ready; a handshake in the flush cycle is void.
REQ-029 mispredict_count SHALL increment by 1 on out_valid && out_ready && out_mispredict && !flush, and saturate at 2^CNT_W-1.
REQ-030 cnt_clr SHALL zero the counter at the next edge, overriding a same-cycle increment.

Reset
REQ-031 On rst_n=0, the block SHALL immediately clear out_valid, out_taken, out_mispredict, out_illegal, out_target and mispredict_count to 0, without waiting for a clock edge.
REQ-032 Reset mid-transaction SHALL discard the held result; the first edge after rst_n rises may accept a request.

Verification
REQ-033 BLT with in_0=0xFFFFFFFF, in_1=1, pc=0x100, imm=0x20, pred_taken=0 -> one cycle later out_valid=1, taken=1, target=0x120, mispredict=1; count=1 after handshake.
REQ-034 BLTU with the same operands, pred_taken=0 -> taken=0, target=0x104, mispredict=0.
REQ-035 out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> back-to-back results, one per cycle.
REQ-036 pc=0xFFFFFFFC, BEQ not taken -> target=0x00000000; mode=010 -> illegal=1, taken=0.
REQ-037 CNT_W=2, five mispredicting handshakes -> count saturates at 3; cnt_clr together with an increment -> 0.
REQ-038 flush while FULL with out_ready=1 and in_valid=1 -> next cycle out_valid=0 and count unchanged; rst_n pulsed low mid-cycle -> outputs 0 asynchronously.
